// File: rtl/shift_rotate_seq.sv
// Serial shift/rotate unit: moves the operand one bit position per clock.
// Supports logical/arithmetic shifts, plain rotates and rotates through carry.
//
// state | meaning
// IDLE  | waiting for start; result/carry_out hold the last completed operation
// RUN   | stepping the working register until the count reaches zero
module shift_rotate_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [2:0]       opcode,
  input  logic [SHW-1:0]   amount,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);

  localparam logic [2:0] OP_SLL  = 3'b000;
  localparam logic [2:0] OP_SRL  = 3'b001;
  localparam logic [2:0] OP_SRA  = 3'b010;
  localparam logic [2:0] OP_ROL  = 3'b011;
  localparam logic [2:0] OP_ROR  = 3'b100;
  localparam logic [2:0] OP_RCL  = 3'b101;
  localparam logic [2:0] OP_RCR  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] work, work_nx, step_w, result_nx;
  logic             carry, carry_nx, step_c, done_nx, cout_nx;
  logic [SHW-1:0]   count, count_nx;
  logic [2:0]       op, op_nx;

  assign busy = (state == RUN);

  // State and datapath registers; result/carry_out only change on the done edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      work      <= '0;
      carry     <= 1'b0;
      count     <= '0;
      op        <= OP_SLL;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
    end else begin
      state     <= state_nx;
      work      <= work_nx;
      carry     <= carry_nx;
      count     <= count_nx;
      op        <= op_nx;
      done      <= done_nx;
      result    <= result_nx;
      carry_out <= cout_nx;
    end
  end

  // One-bit step of the latched operation; the carry takes the bit leaving the word.
  always_comb begin
    step_w = work;
    step_c = carry;
    case (op)
      OP_SLL: begin step_w = {work[WIDTH-2:0], 1'b0};        step_c = work[WIDTH-1]; end
      OP_SRL: begin step_w = {1'b0, work[WIDTH-1:1]};        step_c = work[0];       end
      OP_SRA: begin step_w = {work[WIDTH-1], work[WIDTH-1:1]}; step_c = work[0];     end
      OP_ROL: begin step_w = {work[WIDTH-2:0], work[WIDTH-1]}; step_c = work[WIDTH-1]; end
      OP_ROR: begin step_w = {work[0], work[WIDTH-1:1]};     step_c = work[0];       end
      OP_RCL: begin step_w = {work[WIDTH-2:0], carry};       step_c = work[WIDTH-1]; end
      OP_RCR: begin step_w = {carry, work[WIDTH-1:1]};       step_c = work[0];       end
      default: begin step_w = work;                          step_c = carry;         end
    endcase
  end

  // Next-state logic: accept in IDLE, step while count is non-zero, then publish.
  always_comb begin
    state_nx  = state;
    work_nx   = work;
    carry_nx  = carry;
    count_nx  = count;
    op_nx     = op;
    done_nx   = 1'b0;
    result_nx = result;
    cout_nx   = carry_out;
    case (state)
      IDLE: begin
        if (start) begin
          work_nx  = a;
          carry_nx = cin;
          count_nx = (opcode == OP_PASS) ? '0 : amount;
          op_nx    = opcode;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (count != '0) begin
          work_nx  = step_w;
          carry_nx = step_c;
          count_nx = count - SHW'(1);
        end else begin
          done_nx   = 1'b1;
          result_nx = work;
          cout_nx   = carry;
          state_nx  = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
